led_sweep_ctrl: RTL
===================

LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

Interface
REQ-001 Parameter DIV_W, default 8, sets the prescaler divisor width.
REQ-002 Parameter CNT_W, default 4, sets the pass-count width.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_start, input, 1 bit: start-request level, sampled every cycle.
REQ-006 Port i_stop, input, 1 bit: abort-request level, sampled every cycle.
REQ-007 Port i_mode, input, 2 bits: 0 bounce, 1 sweep-up, 2 sweep-down, 3 hold.
REQ-008 Port i_div, input, DIV_W bits: step once every i_div+1 cycles.
REQ-009 Port i_passes, input, CNT_W bits: number of passes to run; 0 means run until stopped.
REQ-010 Port o_led, output, 8 bits: registered LED pattern.
REQ-011 Port o_index, output, 4 bits: registered current pattern index.
REQ-012 Port o_busy, output, 1 bit: high in RUN.
REQ-013 Port o_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 Pattern table:
- index 0 = 8'h00
- indices 1..8 = one-hot bit (index-1)
- indices 9..14 = one-hot bits 6 down to 1
- index 15 = 8'h00
REQ-015 o_led shall equal table[o_index] in every cycle, with no added latency.
REQ-016 The FSM has states IDLE, RUN and FINISH.
REQ-017 IDLE: o_index=0, o_busy=0, o_done=0.
REQ-018 IDLE to RUN occurs when i_start=1 and i_stop=0. On that edge:
- mode, div and passes are latched
- prescaler and pass counter are cleared
- o_index loads 8 in mode 2, otherwise 1
REQ-019 Start and stop asserted together in IDLE: stop wins and the block stays in IDLE.
REQ-020 Prescaler: counts 0..div_latched. A step tick occurs in the cycle the count equals div_latched, and the count then returns to 0. With div=0 a tick occurs every cycle.
REQ-021 Step on each tick in RUN:
- mode 0: 1→2→…→14→1
- mode 1: 1→…→8→1
- mode 2: 8→…→1→8
- mode 3: index unchanged
REQ-022 A pass completes on the wrap step:
- mode 0: 14→1
- mode 1: 8→1
- mode 2: 1→8
- mode 3: every tick
REQ-023 Pass counter increments on each completed pass. Width is CNT_W and it saturates at all-ones; it never wraps.
REQ-024 Passes nonzero and the completing pass brings the count to passes_latched:
- go to FINISH instead of wrapping
- o_index is set to 0 on the same edge
REQ-025 FINISH lasts exactly one cycle: o_done=1, o_busy=0, o_index=0, then IDLE.
REQ-026 Passes=0: the block stays in RUN indefinitely and never asserts o_done.
REQ-027 i_stop=1 in RUN (any tick phase): IDLE on the next edge, o_index=0, no o_done pulse.
REQ-028 i_start while in RUN or FINISH is ignored; i_mode, i_div and i_passes changes during RUN have no effect.
REQ-029 i_start held high through FINISH starts a new run from IDLE on the following edge; there is no FINISH→RUN shortcut.

Reset
REQ-030 While i_rst=1 on a rising edge, the block shall enter IDLE with:
- o_index=0, o_led=8'h00
- o_busy=0, o_done=0
- prescaler and pass counter at 0
- latched mode, div and passes at 0
REQ-031 i_rst has priority over i_start and i_stop.
REQ-032 i_rst asserted mid-RUN or in FINISH aborts immediately with no o_done pulse.
REQ-033 After reset release the block remains in IDLE until i_start is sampled high.

Verification
REQ-034 Bounce run: mode=0, div=0, passes=1, 1-cycle start.
- o_index steps 1..14 on consecutive cycles, then 0
- o_led steps 01,02,…,80,40,…,02, then 00
- o_done high one cycle
- o_busy high exactly 14 cycles
REQ-035 Sweep-down run: mode=2, div=3, passes=2.
- each index held 4 cycles
- sequence 8..1 twice
- o_done pulses 64 cycles after start
REQ-036 Stop during run: mode=1, div=0, passes=0, i_stop at index 5.
- next cycle o_index=0, o_busy=0
- o_done never asserts
REQ-037 Reset during run: assert i_rst mid-sweep in mode 0.
- all outputs at reset values on the next edge
- a restart begins at index 1
REQ-038 Start and stop high together in IDLE: the block stays in IDLE with o_busy=0.
REQ-039 Mode 3 (hold), div=0, passes=3.
- o_index holds 1 for 3 cycles
- then o_done pulses once

Source files
------------

// File: rtl/led_sweep_ctrl.sv
// rtl/led_sweep_ctrl.sv - LED pattern sequencer with prescaled stepping and pass counting
// Walks an index through a fixed LED pattern table in bounce/sweep/hold modes.
module led_sweep_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_passes,
    output logic [7:0]       o_led,
    output logic [3:0]       o_index,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_index;
    logic [7:0]       r_led;
    logic [DIV_W-1:0] r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_passes;

    state_t           w_state_nxt;
    logic [3:0]       w_index_nxt;
    logic [DIV_W-1:0] w_presc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       w_mode_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_passes_nxt;
    logic [3:0]       w_step_idx;
    logic             w_wrap;
    logic             w_tick;

    function automatic logic [7:0] f_pattern(input logic [3:0] idx);
        logic [7:0] pat;
        pat = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd8) begin
            pat = 8'h01 << (idx - 4'd1);
        end else if (idx >= 4'd9 && idx <= 4'd14) begin
            pat = 8'h01 << (4'd15 - idx);
        end
        return pat;
    endfunction

    assign w_tick    = (r_presc == r_div);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_step_idx = r_index;
        w_wrap     = 1'b0;
        case (r_mode)
            2'd0: begin
                if (r_index == 4'd14) begin
                    w_step_idx = 4'd1;
                    w_wrap     = 1'b1;
                end else begin
                    w_step_idx = r_index + 4'd1;
                end
            end
            2'd1: begin
                if (r_index == 4'd8) begin
                    w_step_idx = 4'd1;
                    w_wrap     = 1'b1;
                end else begin
                    w_step_idx = r_index + 4'd1;
                end
            end
            2'd2: begin
                if (r_index == 4'd1) begin
                    w_step_idx = 4'd8;
                    w_wrap     = 1'b1;
                end else begin
                    w_step_idx = r_index - 4'd1;
                end
            end
            default: begin
                w_step_idx = r_index;
                w_wrap     = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_presc_nxt  = r_presc;
        w_cnt_nxt    = r_cnt;
        w_mode_nxt   = r_mode;
        w_div_nxt    = r_div;
        w_passes_nxt = r_passes;
        case (r_state)
            S_IDLE: begin
                w_index_nxt = 4'd0;
                w_presc_nxt = '0;
                // Stop has priority over a simultaneous start.
                if (i_start && !i_stop) begin
                    w_state_nxt  = S_RUN;
                    w_mode_nxt   = i_mode;
                    w_div_nxt    = i_div;
                    w_passes_nxt = i_passes;
                    w_cnt_nxt    = '0;
                    w_index_nxt  = (i_mode == 2'd2) ? 4'd8 : 4'd1;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_index_nxt = 4'd0;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    w_index_nxt = w_step_idx;
                    if (w_wrap) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (r_passes != '0 && w_cnt_inc == r_passes) begin
                            w_state_nxt = S_FINISH;
                            w_index_nxt = 4'd0;
                        end
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_index  <= 4'd0;
            r_led    <= 8'h00;
            r_presc  <= '0;
            r_cnt    <= '0;
            r_mode   <= 2'd0;
            r_div    <= '0;
            r_passes <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_index  <= w_index_nxt;
            r_led    <= f_pattern(w_index_nxt);
            r_presc  <= w_presc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mode   <= w_mode_nxt;
            r_div    <= w_div_nxt;
            r_passes <= w_passes_nxt;
        end
    end

    assign o_led   = r_led;
    assign o_index = r_index;
    assign o_busy  = (r_state == S_RUN);
    assign o_done  = (r_state == S_FINISH);

endmodule
